// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths and constants for the instruction fetch stage
package if_stage_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC        = 32'd4;
endpackage

// File: rtl/if_stage_pc_reg.sv
// if_stage_pc_reg: register with asynchronous active-low reset to a load value
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] q_o
);
    logic [XLEN-1:0] val_q;
    // capture next value every edge; reset loads RESET_VAL without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) val_q <= RESET_VAL;
        else        val_q <= d_i;
    end
    assign q_o = val_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with branch-predictor redirect and free-running PC
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hit,
    input  logic            taken,
    input  logic [XLEN-1:0] pred_PC,
    input  logic [XLEN-1:0] instr_read,
    output logic            cs_i_n,
    output logic [XLEN-1:0] i_addr,
    output logic [XLEN-1:0] instrCode,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] PC_4_IF
);
    logic [XLEN-1:0] pc_q, pc_d, pc_4, pred_al;
    assign pred_al = pred_PC & ~32'd3;
    assign pc_4    = pc_q + PC_INC;
    // redirect only on a predicted-taken hit; otherwise fall through, wrapping mod 2^32
    always_comb begin
        pc_d = (hit && taken) ? pred_al : pc_4;
    end
    if_stage_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );
    assign i_addr    = pc_q;
    assign PC_IF     = pc_q;
    assign PC_4_IF   = pc_4;
    assign instrCode = rst ? instr_read : NOP_INSTR;
    assign cs_i_n    = ~rst;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a PC model
module tb_if_stage;
    logic        clk, rst, hit, taken, cs_i_n;
    logic [31:0] pred_PC, instr_read, i_addr, instrCode, PC_IF, PC_4_IF;
    int checks = 0, errors = 0;
    logic [31:0] exp_pc;

    if_stage dut (
        .clk(clk), .rst(rst), .hit(hit), .taken(taken), .pred_PC(pred_PC),
        .instr_read(instr_read), .cs_i_n(cs_i_n), .i_addr(i_addr),
        .instrCode(instrCode), .PC_IF(PC_IF), .PC_4_IF(PC_4_IF)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 0; hit = 0; taken = 0; pred_PC = 0; instr_read = 32'hDEAD_BEEF;
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL reset_pc_if got %h exp %h", PC_IF, 32'h0); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL reset_hold_pc got %h exp %h", PC_IF, 32'h0); end
        checks++; if (PC_4_IF !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h exp %h", PC_4_IF, 32'h4); end
        checks++; if (i_addr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h exp %h", i_addr, 32'h0); end
        checks++; if (cs_i_n !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", cs_i_n); end
        checks++; if (instrCode !== 32'h13) begin errors++; $display("FAIL reset_nop got %h exp %h", instrCode, 32'h13); end
    endtask

    task automatic test_sequential();
        @(negedge clk);
        rst = 1; hit = 0; taken = 1; pred_PC = 32'hFFABCD11; instr_read = 32'd1000;
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL seq_first got %h exp %h", PC_IF, 32'h0); end
        checks++; if (instrCode !== 32'd1000) begin errors++; $display("FAIL seq_instr got %h exp %h", instrCode, 32'd1000); end
        checks++; if (cs_i_n !== 1'b0) begin errors++; $display("FAIL seq_cs got %b exp 0", cs_i_n); end
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            checks++; if (PC_IF !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc got %h exp %h", PC_IF, 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        hit = 1; taken = 1; pred_PC = 32'hFFABCD11;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'hFFABCD10) begin errors++; $display("FAIL redir_pc got %h exp %h", PC_IF, 32'hFFABCD10); end
        checks++; if (i_addr !== 32'hFFABCD10) begin errors++; $display("FAIL redir_iaddr got %h exp %h", i_addr, 32'hFFABCD10); end
        checks++; if (PC_4_IF !== 32'hFFABCD14) begin errors++; $display("FAIL redir_pc4 got %h exp %h", PC_4_IF, 32'hFFABCD14); end
    endtask

    task automatic test_not_taken();
        @(negedge clk);
        hit = 1; taken = 1; pred_PC = 32'h100;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'h100) begin errors++; $display("FAIL nt_setup got %h exp %h", PC_IF, 32'h100); end
        @(negedge clk);
        taken = 0; pred_PC = 32'd2000;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'h104) begin errors++; $display("FAIL nt_pc got %h exp %h", PC_IF, 32'h104); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        hit = 1; taken = 1; pred_PC = 32'hFFFFFFFC;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc got %h exp %h", PC_IF, 32'hFFFFFFFC); end
        checks++; if (PC_4_IF !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp %h", PC_4_IF, 32'h0); end
        @(negedge clk);
        hit = 0;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp %h", PC_IF, 32'h0); end
        checks++; if (PC_4_IF !== 32'h4) begin errors++; $display("FAIL wrap_next4 got %h exp %h", PC_4_IF, 32'h4); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        hit = 1; taken = 1; pred_PC = 32'h2000; instr_read = 32'h1234_5678;
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'h2000) begin errors++; $display("FAIL async_setup got %h exp %h", PC_IF, 32'h2000); end
        #2 rst = 0;
        #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL async_pc got %h exp %h", PC_IF, 32'h0); end
        checks++; if (instrCode !== 32'h13) begin errors++; $display("FAIL async_nop got %h exp %h", instrCode, 32'h13); end
        checks++; if (cs_i_n !== 1'b1) begin errors++; $display("FAIL async_cs got %b exp 1", cs_i_n); end
        @(posedge clk); #1;
        checks++; if (PC_IF !== 32'h0) begin errors++; $display("FAIL async_hold got %h exp %h", PC_IF, 32'h0); end
        @(negedge clk);
        rst = 1; hit = 0; taken = 0;
        exp_pc = 32'h0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] want_instr;
            @(negedge clk);
            hit = 1'($urandom); taken = 1'($urandom); pred_PC = $urandom;
            instr_read = $urandom;
            if ($urandom_range(0, 19) == 0) rst = 0;
            else rst = 1;
            if (!rst) exp_pc = 32'h0;
            #1;
            want_instr = rst ? instr_read : 32'h13;
            checks++; if (PC_IF !== exp_pc) begin errors++; $display("FAIL rnd_comb_pc n=%0d got %h exp %h", n, PC_IF, exp_pc); end
            checks++; if (instrCode !== want_instr) begin errors++; $display("FAIL rnd_instr n=%0d got %h exp %h", n, instrCode, want_instr); end
            checks++; if (cs_i_n !== ~rst) begin errors++; $display("FAIL rnd_cs n=%0d got %b exp %b", n, cs_i_n, ~rst); end
            #2;
            hit = 1'($urandom); taken = 1'($urandom); pred_PC = $urandom;
            @(posedge clk);
            if (!rst) exp_pc = 32'h0;
            else if (hit && taken) exp_pc = {pred_PC[31:2], 2'b00};
            else exp_pc = exp_pc + 32'd4;
            #1;
            checks++; if (PC_IF !== exp_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, PC_IF, exp_pc); end
            checks++; if (i_addr !== exp_pc) begin errors++; $display("FAIL rnd_iaddr n=%0d got %h exp %h", n, i_addr, exp_pc); end
            checks++; if (PC_4_IF !== exp_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 n=%0d got %h exp %h", n, PC_4_IF, exp_pc + 32'd4); end
            hit = 1'($urandom); taken = 1'($urandom); pred_PC = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_not_taken();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
